// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction memory write port of the loader
interface imem_loader_if #(
  parameter int N  = 32,
  parameter int AW = 10
);
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;

  // master: byte source plus memory observer; slave: the loader itself
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - assembles a length-prefixed byte stream into instruction memory words
module imem_loader #(
  parameter int N   = 32,
  parameter int INS = 1000,
  parameter int AW  = $clog2(INS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q;
  logic [23:0]   asm_q;
  logic [31:0]   len_q;
  logic [AW-1:0] widx_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [N-1:0]  wdata_q;

  logic          rdy;
  logic          hs;
  logic          word_end;
  logic [N-1:0]  word_full;
  logic          last_word;

  // the fourth byte never lands in asm_q; it is merged straight into the word
  assign rdy       = (state_q == S_LEN) || (state_q == S_LOAD);
  assign hs        = rdy && bus.in_valid;
  assign word_end  = hs && (cnt_q == 2'd3);
  assign word_full = {bus.in_data, asm_q};
  assign last_word = (({{(32-AW){1'b0}}, widx_q} + 32'd1) == len_q);

  assign bus.in_ready  = rdy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = rdy;
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign cpu_hold      = (state_q != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LEN;
      S_LEN: begin
        if (word_end) begin
          if (word_full == 32'd0)             state_d = S_DONE;
          else if (word_full > 32'(INS))      state_d = S_ERR;
          else                                state_d = S_LOAD;
        end
      end
      S_LOAD: if (word_end && last_word) state_d = S_DONE;
      S_DONE: if (start) state_d = S_LEN;
      S_ERR:  if (start) state_d = S_LEN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      asm_q   <= 24'd0;
      len_q   <= 32'd0;
      widx_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (!rdy) begin
        if (start) begin
          cnt_q  <= 2'd0;
          widx_q <= '0;
        end
      end else if (hs) begin
        cnt_q <= cnt_q + 2'd1;
        case (cnt_q)
          2'd0:    asm_q[7:0]   <= bus.in_data;
          2'd1:    asm_q[15:8]  <= bus.in_data;
          2'd2:    asm_q[23:16] <= bus.in_data;
          default: ;
        endcase
        if (cnt_q == 2'd3) begin
          if (state_q == S_LEN) begin
            len_q  <= word_full;
            widx_q <= '0;
          end else begin
            we_q    <= 1'b1;
            addr_q  <= widx_q;
            wdata_q <= word_full;
            widx_q  <= widx_q + AW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;
  localparam int INS = 1000;
  localparam int AW  = $clog2(INS);

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done, err, cpu_hold;
  int   tests = 0;
  int   fails = 0;

  imem_loader_if #(.N(32), .AW(AW)) bus ();

  imem_loader #(.N(32), .INS(INS), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus.slave),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  // every write pulse, with the status seen in that same cycle
  logic [AW-1:0] w_addr[$];
  logic [31:0]   w_data[$];
  logic          w_done[$];
  logic          w_hold[$];
  logic          w_rdy[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      w_addr.push_back(bus.mem_addr);
      w_data.push_back(bus.mem_wdata);
      w_done.push_back(done);
      w_hold.push_back(cpu_hold);
      w_rdy.push_back(bus.in_ready);
    end
  end

  int          exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done, exp_err;

  task automatic clear_log();
    w_addr.delete(); w_data.delete(); w_done.delete(); w_hold.delete(); w_rdy.delete();
  endtask

  // program image -> expected writes: 32-bit LE count, then count LE words
  task automatic model(input logic [7:0] p[$]);
    logic [31:0] len;
    exp_addr.delete(); exp_data.delete();
    len = {p[3], p[2], p[1], p[0]};
    exp_done = 1'b0; exp_err = 1'b0;
    if (len == 0) exp_done = 1'b1;
    else if (len > INS) exp_err = 1'b1;
    else begin
      for (int i = 0; i < int'(len); i++) begin
        exp_addr.push_back(i);
        exp_data.push_back({p[4*i+7], p[4*i+6], p[4*i+5], p[4*i+4]});
      end
      exp_done = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_byte_timeout byte=%02h in_ready never seen high", b);
    end
  endtask

  task automatic drive_prog(input logic [7:0] p[$], input int maxgap);
    pulse_start();
    foreach (p[i]) send_byte(p[i], (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (cpu_hold !== 1'b1)     begin fails++; $display("FAIL rst_cpu_hold got=%b exp=1", cpu_hold); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    tests++; if (bus.mem_we !== 1'b0)   begin fails++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
    tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0)         begin fails++; $display("FAIL rst_done got=%b exp=0", done); end
    tests++; if (err !== 1'b0)          begin fails++; $display("FAIL rst_err got=%b exp=0", err); end
    tests++; if (bus.mem_addr !== '0)   begin fails++; $display("FAIL rst_mem_addr got=%0d exp=0", bus.mem_addr); end
    tests++; if (bus.mem_wdata !== '0)  begin fails++; $display("FAIL rst_mem_wdata got=%h exp=0", bus.mem_wdata); end
  endtask

  task automatic test_two_words(input int maxgap);
    logic [7:0] p[$];
    p = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    clear_log();
    model(p);
    drive_prog(p, maxgap);
    tests++; if (w_addr.size() !== 2) begin fails++; $display("FAIL two_words_count gap=%0d got=%0d exp=2", maxgap, w_addr.size()); end
    for (int i = 0; i < 2; i++) begin
      tests++; if (w_addr[i] !== AW'(exp_addr[i])) begin fails++; $display("FAIL two_words_addr%0d got=%0d exp=%0d", i, w_addr[i], exp_addr[i]); end
      tests++; if (w_data[i] !== exp_data[i])      begin fails++; $display("FAIL two_words_data%0d got=%h exp=%h", i, w_data[i], exp_data[i]); end
    end
    tests++; if (w_done[0] !== 1'b0 || w_rdy[0] !== 1'b1) begin fails++; $display("FAIL first_pulse_status done=%b rdy=%b exp done=0 rdy=1", w_done[0], w_rdy[0]); end
    tests++; if (w_done[1] !== 1'b1) begin fails++; $display("FAIL last_pulse_done got=%b exp=1", w_done[1]); end
    tests++; if (w_hold[1] !== 1'b0) begin fails++; $display("FAIL last_pulse_cpu_hold got=%b exp=0", w_hold[1]); end
    tests++; if (w_rdy[1] !== 1'b0)  begin fails++; $display("FAIL last_pulse_in_ready got=%b exp=0", w_rdy[1]); end
    tests++; if (done !== exp_done || cpu_hold !== 1'b0) begin fails++; $display("FAIL two_words_final done=%b hold=%b exp done=1 hold=0", done, cpu_hold); end
  endtask

  task automatic test_random();
    logic [7:0] p[$];
    int n;
    for (int t = 0; t < 5; t++) begin
      n = $urandom_range(1, 7);
      p.delete();
      p.push_back(8'(n)); p.push_back(8'h00); p.push_back(8'h00); p.push_back(8'h00);
      for (int i = 0; i < 4 * n; i++) p.push_back(8'($urandom));
      clear_log();
      model(p);
      drive_prog(p, $urandom_range(0, 3));
      tests++; if (w_addr.size() !== exp_addr.size()) begin fails++; $display("FAIL rand%0d_count got=%0d exp=%0d", t, w_addr.size(), exp_addr.size()); end
      foreach (exp_addr[i]) begin
        tests++; if (w_addr[i] !== AW'(exp_addr[i]) || w_data[i] !== exp_data[i]) begin
          fails++; $display("FAIL rand%0d_word%0d got=%0d:%h exp=%0d:%h", t, i, w_addr[i], w_data[i], exp_addr[i], exp_data[i]);
        end
      end
      tests++; if (done !== exp_done || err !== exp_err) begin fails++; $display("FAIL rand%0d_final done=%b err=%b exp done=%b err=%b", t, done, err, exp_done, exp_err); end
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] p[$];
    p = '{8'h00, 8'h00, 8'h00, 8'h00};
    clear_log();
    pulse_start();
    foreach (p[i]) send_byte(p[i], 0);
    tests++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin fails++; $display("FAIL zero_len_done done=%b hold=%b exp done=1 hold=0", done, cpu_hold); end
    repeat (2) @(negedge clk);
    tests++; if (w_addr.size() !== 0) begin fails++; $display("FAIL zero_len_writes got=%0d exp=0", w_addr.size()); end
    pulse_start();
    tests++; if (cpu_hold !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL zero_len_restart hold=%b busy=%b done=%b exp 1 1 0", cpu_hold, busy, done); end
    pulse_start();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL start_in_len_ignored busy=%b exp=1", busy); end
    do_reset();
  endtask

  task automatic test_range();
    logic [7:0] p[$];
    p = '{8'hE9, 8'h03, 8'h00, 8'h00};
    clear_log();
    drive_prog(p, 1);
    tests++; if (err !== 1'b1 || bus.in_ready !== 1'b0 || cpu_hold !== 1'b1) begin fails++; $display("FAIL range_1001 err=%b rdy=%b hold=%b exp 1 0 1", err, bus.in_ready, cpu_hold); end
    tests++; if (w_addr.size() !== 0) begin fails++; $display("FAIL range_1001_writes got=%0d exp=0", w_addr.size()); end
    p = '{8'h01, 8'h00, 8'h00, 8'h01};
    drive_prog(p, 0);
    tests++; if (err !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL range_upper_bits err=%b done=%b exp err=1 done=0", err, done); end
    p = '{8'hE8, 8'h03, 8'h00, 8'h00};
    drive_prog(p, 0);
    tests++; if (err !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL range_1000 err=%b busy=%b rdy=%b exp 0 1 1", err, busy, bus.in_ready); end
    do_reset();
  endtask

  task automatic test_mid_reset();
    logic [7:0] p[$];
    clear_log();
    p = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    pulse_start();
    foreach (p[i]) send_byte(p[i], 0);
    do_reset();
    @(negedge clk);
    tests++; if (w_addr.size() !== 1 || w_addr[0] !== '0 || w_data[0] !== 32'h44332211) begin
      fails++; $display("FAIL mid_reset_writes n=%0d first=%0d:%h exp n=1 0:44332211", w_addr.size(), w_addr[0], w_data[0]);
    end
    tests++; if (busy !== 1'b0 || bus.in_ready !== 1'b0 || cpu_hold !== 1'b1 || bus.mem_wdata !== '0) begin
      fails++; $display("FAIL mid_reset_idle busy=%b rdy=%b hold=%b wdata=%h exp 0 0 1 0", busy, bus.in_ready, cpu_hold, bus.mem_wdata);
    end
    clear_log();
    p = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
    model(p);
    drive_prog(p, 2);
    tests++; if (w_addr.size() !== 1 || w_addr[0] !== AW'(exp_addr[0]) || w_data[0] !== exp_data[0]) begin
      fails++; $display("FAIL reload_write n=%0d got=%0d:%h exp n=1 %0d:%h", w_addr.size(), w_addr[0], w_data[0], exp_addr[0], exp_data[0]);
    end
    tests++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin fails++; $display("FAIL reload_done done=%b hold=%b exp 1 0", done, cpu_hold); end
  endtask

  initial begin
    test_reset();
    test_two_words(0);
    test_two_words(3);
    test_random();
    test_zero_len();
    test_range();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
